tetris_row_clear: RTL



---
 rtl/tetris_row_clear.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tetris_row_clear.sv
// Row-clear engine: scans the board bottom-up, removes full rows by shifting
// everything above them down one row, clears row 0, and counts removed rows.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for start
// S_SCAN_RD   | present cell (r,c) to the board RAM
// S_SCAN_CHK  | inspect cell (r,c); decide empty / next column / row full
// S_SHIFT_RD  | present cell (d-1,c) to the board RAM
// S_SHIFT_WR  | write cell (d-1,c) into (d,c)
// S_CLEAR_TOP | write zero into (0,c)
// S_DONE      | one-cycle completion pulse
module tetris_row_clear #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int CELL_W = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CELL_W-1:0] wr_data
);

  localparam int RW = 5;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]     C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0]     R_LAST = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_RD,
    S_SCAN_CHK,
    S_SHIFT_RD,
    S_SHIFT_WR,
    S_CLEAR_TOP,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   r, r_n;
  logic [RW-1:0]   d, d_n;
  logic [CW-1:0]   c, c_n;
  logic [4:0]      lc_n;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] row,
                                                  input logic [CW-1:0] col);
    return ADDR_W'(row) * COLS_A + ADDR_W'(col);
  endfunction

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      r             <= '0;
      c             <= '0;
      d             <= '0;
      lines_cleared <= '0;
    end else begin
      state         <= state_n;
      r             <= r_n;
      c             <= c_n;
      d             <= d_n;
      lines_cleared <= lc_n;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_n = state;
    r_n     = r;
    c_n     = c;
    d_n     = d;
    lc_n    = lines_cleared;
    case (state)
      S_IDLE: begin
        if (start) begin
          r_n     = R_LAST;
          c_n     = '0;
          lc_n    = '0;
          state_n = S_SCAN_RD;
        end
      end
      S_SCAN_RD: state_n = S_SCAN_CHK;
      S_SCAN_CHK: begin
        if (rd_data == '0) begin
          c_n = '0;
          if (r == '0) begin
            state_n = S_DONE;
          end else begin
            r_n     = r - 1'b1;
            state_n = S_SCAN_RD;
          end
        end else if (c != C_LAST) begin
          c_n     = c + 1'b1;
          state_n = S_SCAN_RD;
        end else begin
          lc_n    = lines_cleared + 5'd1;
          d_n     = r;
          c_n     = '0;
          state_n = (r == '0) ? S_CLEAR_TOP : S_SHIFT_RD;
        end
      end
      S_SHIFT_RD: state_n = S_SHIFT_WR;
      S_SHIFT_WR: begin
        if (c != C_LAST) begin
          c_n     = c + 1'b1;
          state_n = S_SHIFT_RD;
        end else begin
          c_n = '0;
          if (d == RW'(1)) begin
            state_n = S_CLEAR_TOP;
          end else begin
            d_n     = d - 1'b1;
            state_n = S_SHIFT_RD;
          end
        end
      end
      S_CLEAR_TOP: begin
        if (c != C_LAST) begin
          c_n = c + 1'b1;
        end else begin
          c_n     = '0;
          state_n = S_SCAN_RD;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Moore memory and status outputs decoded from state and counters.
  // During write states rd_addr is parked on a cell other than the write
  // target (source cell while shifting, row 1 while clearing row 0).
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state)
      S_SCAN_RD, S_SCAN_CHK: begin
        busy    = 1'b1;
        rd_addr = cell_addr(r, c);
      end
      S_SHIFT_RD: begin
        busy    = 1'b1;
        rd_addr = cell_addr(d - 1'b1, c);
      end
      S_SHIFT_WR: begin
        busy    = 1'b1;
        rd_addr = cell_addr(d - 1'b1, c);
        wr_en   = 1'b1;
        wr_addr = cell_addr(d, c);
        wr_data = rd_data;
      end
      S_CLEAR_TOP: begin
        busy    = 1'b1;
        rd_addr = COLS_A;
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(c);
        wr_data = '0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
